// File: rtl/pwm_capture_multi.sv
// pwm_capture_multi: multi-channel PWM capture.
// Each channel synchronises its PWM line and measures the period and high
// time in clk cycles between consecutive rising edges. Every completed
// measurement (or stuck-line timeout) is reported with a one-cycle valid
// strobe. A line with no rising edge for TIMEOUT cycles is reported as
// stuck, either low or high.
module pwm_capture_multi #(
  parameter int CH      = 3,
  parameter int W       = 16,
  parameter int TIMEOUT = 65535
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            en,
  input  logic [CH-1:0]   pwm_in,
  output logic [CH*W-1:0] period_o,
  output logic [CH*W-1:0] high_o,
  output logic [CH-1:0]   valid_o,
  output logic [CH-1:0]   stuck_o
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEAS = 1'b1
  } state_t;

  localparam logic [W-1:0] TIMEOUT_W = W'(TIMEOUT);
  localparam logic [W-1:0] ONE_W     = W'(1);

  // Input path: two-flop synchroniser followed by an edge-history flop.
  logic [CH-1:0] s1_q, s1_d;
  logic [CH-1:0] s2_q, s2_d;
  logic [CH-1:0] p_q, p_d;
  logic [CH-1:0] rise;

  // Per-channel measurement state.
  state_t        state_q  [CH];
  state_t        state_d  [CH];
  logic [W-1:0]  pcnt_q   [CH];
  logic [W-1:0]  pcnt_d   [CH];
  logic [W-1:0]  hcnt_q   [CH];
  logic [W-1:0]  hcnt_d   [CH];

  // Registered results.
  logic [W-1:0]  period_q [CH];
  logic [W-1:0]  period_d [CH];
  logic [W-1:0]  high_q   [CH];
  logic [W-1:0]  high_d   [CH];
  logic [CH-1:0] valid_q, valid_d;
  logic [CH-1:0] stuck_q, stuck_d;

  // Synchroniser chain keeps running regardless of en so that a line which
  // is already high when capture is enabled does not look like an edge.
  always_comb begin
    s1_d = pwm_in;
    s2_d = s1_q;
    p_d  = s2_q;
  end

  assign rise = s2_q & ~p_q;

  // Per-channel measurement FSM: count period/high cycles, report on each
  // rising edge, and fall back to IDLE on timeout or when en drops.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i]  = state_q[i];
      pcnt_d[i]   = pcnt_q[i];
      hcnt_d[i]   = hcnt_q[i];
      period_d[i] = period_q[i];
      high_d[i]   = high_q[i];
      stuck_d[i]  = stuck_q[i];
      valid_d[i]  = 1'b0;

      if (!en) begin
        // Partial measurement is discarded; last results stay visible.
        state_d[i] = ST_IDLE;
        pcnt_d[i]  = '0;
        hcnt_d[i]  = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            pcnt_d[i] = '0;
            hcnt_d[i] = '0;
            // First edge only arms the channel; no result yet.
            if (rise[i]) begin
              pcnt_d[i]  = ONE_W;
              hcnt_d[i]  = ONE_W;
              state_d[i] = ST_MEAS;
            end
          end
          ST_MEAS: begin
            if (rise[i]) begin
              // Edge wins over a coincident timeout.
              period_d[i] = pcnt_q[i];
              high_d[i]   = hcnt_q[i];
              stuck_d[i]  = 1'b0;
              valid_d[i]  = 1'b1;
              pcnt_d[i]   = ONE_W;
              hcnt_d[i]   = ONE_W;
            end else if (pcnt_q[i] == TIMEOUT_W) begin
              // No edge for TIMEOUT cycles: line stuck at its current level.
              period_d[i] = '0;
              high_d[i]   = s2_q[i] ? TIMEOUT_W : '0;
              stuck_d[i]  = s2_q[i];
              valid_d[i]  = 1'b1;
              pcnt_d[i]   = '0;
              hcnt_d[i]   = '0;
              state_d[i]  = ST_IDLE;
            end else begin
              pcnt_d[i] = pcnt_q[i] + ONE_W;
              if (s2_q[i]) begin
                hcnt_d[i] = hcnt_q[i] + ONE_W;
              end
            end
          end
        endcase
      end
    end
  end

  // State and result registers, all cleared asynchronously by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      p_q     <= '0;
      valid_q <= '0;
      stuck_q <= '0;
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= ST_IDLE;
        pcnt_q[i]   <= '0;
        hcnt_q[i]   <= '0;
        period_q[i] <= '0;
        high_q[i]   <= '0;
      end
    end else begin
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      p_q     <= p_d;
      valid_q <= valid_d;
      stuck_q <= stuck_d;
      for (int i = 0; i < CH; i++) begin
        state_q[i]  <= state_d[i];
        pcnt_q[i]   <= pcnt_d[i];
        hcnt_q[i]   <= hcnt_d[i];
        period_q[i] <= period_d[i];
        high_q[i]   <= high_d[i];
      end
    end
  end

  // Pack per-channel results onto the flat output buses.
  for (genvar g = 0; g < CH; g++) begin : g_pack
    assign period_o[g*W +: W] = period_q[g];
    assign high_o[g*W +: W]   = high_q[g];
  end

  assign valid_o = valid_q;
  assign stuck_o = stuck_q;

endmodule

// File: tb/tb_pwm_capture_multi.sv
// Bench for pwm_capture_multi: waveforms are generated per channel, expected
// results are derived from the driven waveform and queued with the cycle in
// which valid_o must appear, then matched against DUT output.
module tb_pwm_capture_multi;

  localparam int CH = 3;
  localparam int W  = 16;
  localparam int TO = 200;

  localparam int M_PWM  = 0;
  localparam int M_LOW  = 1;
  localparam int M_HIGH = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic            en;
  logic [CH-1:0]   pwm_in;
  logic [CH*W-1:0] period_o;
  logic [CH*W-1:0] high_o;
  logic [CH-1:0]   valid_o;
  logic [CH-1:0]   stuck_o;

  pwm_capture_multi #(.CH(CH), .W(W), .TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .en       (en),
    .pwm_in   (pwm_in),
    .period_o (period_o),
    .high_o   (high_o),
    .valid_o  (valid_o),
    .stuck_o  (stuck_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int at;
    int ch;
    int per;
    int hi;
    bit st;
  } exp_t;

  exp_t sb[$];

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int sim_cnt     = 0;
  int tt          = 0;

  int mode_c [CH];
  int per_c  [CH];
  int hi_c   [CH];
  int ph_c   [CH];

  bit pv     [CH];
  bit meas   [CH];
  int last_e [CH];
  int hc     [CH];

  int last_per [CH];
  int last_hi  [CH];
  bit last_st  [CH];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic bit line_val(input int c, input int t);
    if (mode_c[c] == M_LOW)  return 1'b0;
    if (mode_c[c] == M_HIGH) return 1'b1;
    return ((t + ph_c[c]) % per_c[c]) < hi_c[c];
  endfunction

  task automatic cfg(input int c, input int m, input int p, input int h, input int ph);
    mode_c[c] = m;
    per_c[c]  = p;
    hi_c[c]   = h;
    ph_c[c]   = ph;
  endtask

  task automatic push(input int c, input int at, input int p, input int h, input bit s);
    exp_t x;
    x.at  = at;
    x.ch  = c;
    x.per = p;
    x.hi  = h;
    x.st  = s;
    sb.push_back(x);
  endtask

  // One input cycle: drive the lines and queue any result the waveform implies.
  task automatic step();
    logic [CH-1:0] v;
    int e;
    @(negedge clk);
    e = cyc + 1;
    for (int c = 0; c < CH; c++) v[c] = line_val(c, tt);
    for (int c = 0; c < CH; c++) begin
      if (reset) begin
        meas[c] = 1'b0;
        pv[c]   = 1'b0;
      end else begin
        if (!en) begin
          meas[c] = 1'b0;
        end else if (meas[c]) begin
          if (v[c] && !pv[c]) begin
            push(c, e + 2, e - last_e[c], hc[c], 1'b0);
            last_e[c] = e;
            hc[c]     = 1;
          end else if (e - last_e[c] == TO) begin
            push(c, e + 2, 0, v[c] ? TO : 0, v[c]);
            meas[c] = 1'b0;
          end else if (v[c]) begin
            hc[c]++;
          end
        end else if (v[c] && !pv[c]) begin
          meas[c]   = 1'b1;
          last_e[c] = e;
          hc[c]     = 1;
        end
        pv[c] = v[c];
      end
    end
    pwm_in = v;
    tt++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Match every valid pulse against the queue; flag late or missing results.
  always @(posedge clk) begin : mon
    exp_t x;
    int   idx;
    #1;
    if (valid_o == '1) sim_cnt++;
    for (int c = 0; c < CH; c++) begin
      if (valid_o[c]) begin
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
          if (idx < 0 && sb[i].at == cyc && sb[i].ch == c) idx = i;
        end
        if (idx >= 0) begin
          x = sb[idx];
          sb.delete(idx);
          chk($sformatf("period_ch%0d", c), 64'(period_o[c*W +: W]), 64'(x.per));
          chk($sformatf("high_ch%0d", c),   64'(high_o[c*W +: W]),   64'(x.hi));
          chk($sformatf("stuck_ch%0d", c),  64'(stuck_o[c]),         64'(x.st));
          last_per[c] = x.per;
          last_hi[c]  = x.hi;
          last_st[c]  = x.st;
        end else begin
          chk($sformatf("spurious_valid_ch%0d", c), 64'(valid_o[c]), 64'd0);
        end
      end
    end
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      chk($sformatf("missing_valid_ch%0d", sb[0].ch), 64'(valid_o[sb[0].ch]), 64'd1);
      void'(sb.pop_front());
    end
  end

  initial begin : stim
    logic [CH*W-1:0] ep, eh;
    logic [CH-1:0]   es;

    reset  = 1'b1;
    en     = 1'b0;
    pwm_in = '0;
    for (int c = 0; c < CH; c++) begin
      cfg(c, M_LOW, 100, 10, 0);
      pv[c] = 1'b0; meas[c] = 1'b0; last_e[c] = 0; hc[c] = 0;
      last_per[c] = 0; last_hi[c] = 0; last_st[c] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("rst_period", 64'(period_o), 64'd0);
    chk("rst_high",   64'(high_o),   64'd0);
    chk("rst_valid",  64'(valid_o),  64'd0);
    chk("rst_stuck",  64'(stuck_o),  64'd0);
    reset = 1'b0;
    run(3);
    en = 1'b1;

    // Single channel steady PWM 10/100.
    cfg(0, M_PWM, 100, 10, 0);
    run(450);

    // Three channels, offset phases then aligned.
    cfg(0, M_PWM, 100, 10, 0);
    cfg(1, M_PWM, 100, 20, 30);
    cfg(2, M_PWM, 100, 50, 60);
    run(350);
    cfg(1, M_PWM, 100, 20, 0);
    cfg(2, M_PWM, 100, 50, 0);
    run(350);
    chk("aligned_simultaneous", 64'(sim_cnt != 0), 64'd1);

    // Stuck lines: ch0/ch1 low, ch2 high.
    cfg(0, M_LOW, 100, 0, 0);
    cfg(1, M_LOW, 100, 0, 0);
    cfg(2, M_HIGH, 100, 0, 0);
    run(TO + 60);
    chk("stuck_flags",  64'(stuck_o),  64'b100);
    chk("stuck_period", 64'(period_o), 64'd0);
    chk("stuck_high",   64'(high_o),   64'h00C8_0000_0000);
    for (int c = 0; c < CH; c++) cfg(c, M_PWM, 100, 10, 0);
    run(150);

    // Period exactly TIMEOUT vs TIMEOUT+1.
    cfg(0, M_PWM, TO, 5, 0);
    cfg(1, M_PWM, TO + 1, 5, 0);
    cfg(2, M_LOW, 100, 0, 0);
    run(700);

    // en dropped for 5 cycles mid-period.
    cfg(0, M_PWM, 100, 10, 0);
    cfg(1, M_PWM, 100, 20, 0);
    cfg(2, M_PWM, 100, 40, 0);
    run(250);
    while (tt % 100 != 50) step();
    en = 1'b0;
    run(5);
    for (int c = 0; c < CH; c++) begin
      ep[c*W +: W] = 16'(last_per[c]);
      eh[c*W +: W] = 16'(last_hi[c]);
      es[c]        = last_st[c];
    end
    chk("en_low_hold_period", 64'(period_o), 64'(ep));
    chk("en_low_hold_high",   64'(high_o),   64'(eh));
    chk("en_low_hold_stuck",  64'(stuck_o),  64'(es));
    chk("en_low_valid",       64'(valid_o),  64'd0);
    en = 1'b1;
    run(250);

    // Asynchronous reset between clock edges.
    run(130);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("async_rst_period", 64'(period_o), 64'd0);
    chk("async_rst_high",   64'(high_o),   64'd0);
    chk("async_rst_valid",  64'(valid_o),  64'd0);
    chk("async_rst_stuck",  64'(stuck_o),  64'd0);
    sb.delete();
    for (int c = 0; c < CH; c++) cfg(c, M_LOW, 100, 0, 0);
    run(2);
    reset = 1'b0;
    for (int c = 0; c < CH; c++) cfg(c, M_PWM, 100, 10, 0);
    run(250);

    // Narrow pulses.
    cfg(0, M_PWM, 2, 1, 0);
    cfg(1, M_PWM, 2, 1, 1);
    cfg(2, M_PWM, 3, 1, 0);
    run(40);

    // Drain: lines quiet, every queued result must have been seen.
    for (int c = 0; c < CH; c++) cfg(c, M_LOW, 100, 0, 0);
    run(5);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
